fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised, vendor-independent synchronous FIFO built on inferred simple-dual-port RAM. It is the generalised successor to the primitive-wrapped fifo_sync: arbitrary width and depth, selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full and almost-empty flags, an occupancy count, and sticky overflow/underflow error flags. It sits between single-clock producers and consumers, such as UART/VGA data paths, in the same clock domain.

Parameters:
DATA_WIDTH, 72, word width in bits (1..256)
ADDR_WIDTH, 9, log2 of depth; DEPTH = 2**ADDR_WIDTH (2..16)
FWFT, 0, 0 = standard read (1-cycle latency); 1 = first-word-fall-through
AFULL_THRESH, 2**ADDR_WIDTH-16, almost_full asserts when count >= value
AEMPTY_THRESH, 16, almost_empty asserts when count <= value

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
rd_en  in  1  read request (standard) / pop acknowledge (FWFT)
rd_data  out  DATA_WIDTH  read word
rd_valid  out  1  standard: pulses 1 cycle when rd_data is new; FWFT: equals !empty
ready  out  1  FIFO accepting traffic
full  out  1  no free entry
empty  out  1  no readable word
almost_full  out  1  count >= AFULL_THRESH
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  ADDR_WIDTH+1  words held, including the FWFT output register
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (rst low, asynchronous): pointers, count, rd_data, rd_valid, overflow, underflow, ready and almost_full are 0. full=1, empty=1, almost_empty=1. RAM contents are not cleared.
- ready: set on the 2nd rising clk edge after rst deasserts (2-flop synchronised release). While ready=0, wr_en and rd_en are ignored and do not set the error flags.
- A write is accepted when wr_en && ready && (!full || read accepted in the same cycle). A rejected write (wr_en && full && no accepted read) sets overflow and leaves the data unchanged.
- Standard mode: a read is accepted when rd_en && !empty. rd_data and rd_valid update at the edge after acceptance (latency 1). rd_data holds its value otherwise. rd_en && empty sets underflow.
- FWFT mode: the head word is presented at rd_data with empty=0. rd_en && !empty pops it, and the next word (if any) appears at the following edge. A write to an empty FIFO at edge N makes empty=0 and the word visible after edge N+1 (RAM read plus output register). rd_en while empty sets underflow.
- Simultaneous read and write: both are performed and count is unchanged. This includes the full case. When the FIFO is empty, the write proceeds and the read is rejected.
- Pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH. full/empty are derived from MSB inequality/equality, are registered, and update at the same edge as count.
- count, almost_full and almost_empty are registered and updated at the same edge as the pointers.
- overflow and underflow clear only on reset.

Decomposition:
- Package fifo_pkg: mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1; a clog2 function; a parameter-legality check macro (AFULL_THRESH <= DEPTH, AEMPTY_THRESH < DEPTH).
- Sub-module sdp_ram: one write port and one registered read port with read enable; inferred block RAM; parameters DATA_WIDTH and ADDR_WIDTH.

Test Plan:
- Reset/ready: hold rst low for 6 cycles, then release -> ready rises at the 2nd edge; empty=1, full=0, count=0. Writes issued before ready are dropped and overflow stays 0.
- Standard fill/drain, DEPTH=16, AFULL_THRESH=12, AEMPTY_THRESH=2:
  - Write 16 random words -> almost_empty clears at count=3, almost_full sets at count=12, full sets at 16.
  - A 17th write -> overflow=1 and count stays 16.
  - Read 16 words -> data in order with rd_valid lagging rd_en by 1 cycle.
  - A 17th read -> underflow=1.
- FWFT latency: write 0x0A5 at edge N into an empty FIFO -> rd_data=0x0A5 and empty=0 after edge N+1. Pop -> empty=1 at the next edge.
- Simultaneous access at full: rd_en=wr_en=1 for 20 cycles -> count stays 16, overflow stays 0, and read order remains FIFO through pointer wrap.
- Simultaneous access at empty: rd_en=wr_en=1 on an empty FIFO -> write is accepted, count=1, underflow=1.
- Mid-operation reset: assert rst with count=9 between edges -> outputs go to their reset values immediately without waiting for clk; subsequent traffic starts from address 0.

Source files
------------

// File: rtl/fifo_sync_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Latency: n/a (compile-time only).
// Backpressure: n/a.

`ifndef FIFO_SYNC_PARAM_PKG_SV
`define FIFO_SYNC_PARAM_PKG_SV

// Elaboration-time threshold sanity check, expanded inside the FIFO body.
`define FIFO_CHECK_PARAMS(DEPTH_V, AF_V, AE_V) \
  if (!(((AF_V) <= (DEPTH_V)) && ((AE_V) < (DEPTH_V)))) begin : g_bad_thresholds \
    $error("fifo_sync_param: AFULL_THRESH must be <= DEPTH and AEMPTY_THRESH < DEPTH"); \
  end

package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

`endif

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle of the synchronous FIFO.
// Latency: n/a (wiring only).
// Backpressure: full/ready towards the producer, empty/rd_valid towards the consumer.
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 9
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  ready;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, ready, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, ready, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Latency: rd_data_o updates one clk after rd_en_i; read-before-write on address collision.
// Backpressure: none, the caller sequences the enables.
module sdp_ram #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Registered read; holds its last word when not enabled, clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Synchronous FIFO on inferred SDP RAM, standard or first-word-fall-through read.
// Latency: standard read 1 clk after rd_en; FWFT head visible 2 edges after a write into empty.
// Backpressure: writes dropped when full (overflow), reads dropped when empty (underflow).
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 72,
  parameter int ADDR_WIDTH    = 9,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 16,
  parameter int AEMPTY_THRESH = 16
) (
  input  logic              clk,
  input  logic              rst,
  fifo_sync_param_if.slave  bus
);

  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam bit                IS_FWFT = (FWFT == FIFO_MODE_FWFT);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  `FIFO_CHECK_PARAMS(DEPTH, AFULL_THRESH, AEMPTY_THRESH)

  logic [1:0]            rst_sync_q;
  logic                  ready_q;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  afull_q, afull_d, aempty_q, aempty_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d, rd_valid_q;
  logic                  rd_acc, wr_acc, ram_re, ptr_full;

  // Two-flop release of the reset; traffic is ignored until ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign ready_q = rst_sync_q[1];

  // Accept decisions and next-state of pointers, occupancy and flags.
  always_comb begin
    rd_acc   = ready_q && bus.rd_en && !empty_q;
    wr_acc   = ready_q && bus.wr_en && (!full_q || rd_acc);
    // FWFT refills the output register whenever it is empty or being popped.
    ram_re   = IS_FWFT ? ((wr_ptr_q != rd_ptr_q) && (empty_q || rd_acc)) : rd_acc;
    wr_ptr_d = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = ram_re ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d  = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + PTR_ONE;
    else if (!wr_acc && rd_acc) count_d = count_q - PTR_ONE;
    ptr_full = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
               (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
    // In FWFT the output register holds one word, so capacity follows count.
    full_d   = !rst_sync_q[0] || (IS_FWFT ? (count_d == DEPTH_C) : ptr_full);
    empty_d  = IS_FWFT ? !(ram_re || (!empty_q && !rd_acc)) : (wr_ptr_d == rd_ptr_d);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
    ovf_d    = ovf_q || (ready_q && bus.wr_en && full_q && !rd_acc);
    udf_d    = udf_q || (ready_q && bus.rd_en && empty_q);
  end

  // Status and pointer registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b1;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_acc;
    end
  end

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (bus.wr_data),
    .rd_en_i   (ram_re),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (bus.rd_data)
  );

  assign bus.rd_valid     = IS_FWFT ? !empty_q : rd_valid_q;
  assign bus.ready        = ready_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: one standard-mode and one FWFT instance, DEPTH=16.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: exercised through overflow/underflow and simultaneous access cases.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [71:0] sdat [16];

  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_WIDTH(72), .ADDR_WIDTH(4)) s_if ();
  fifo_sync_param_if #(.DATA_WIDTH(72), .ADDR_WIDTH(4)) f_if ();

  fifo_sync_param #(.DATA_WIDTH(72), .ADDR_WIDTH(4), .FWFT(0), .AFULL_THRESH(12), .AEMPTY_THRESH(2))
    u_std (.clk(clk), .rst(rst), .bus(s_if));
  fifo_sync_param #(.DATA_WIDTH(72), .ADDR_WIDTH(4), .FWFT(1), .AFULL_THRESH(12), .AEMPTY_THRESH(2))
    u_fwft (.clk(clk), .rst(rst), .bus(f_if));

  task automatic idle_inputs();
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.wr_data = '0;
    f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.wr_data = '0;
  endtask

  // Bounded wait for ready after reset release.
  task automatic wait_ready();
    int k;
    k = 0;
    while (s_if.ready !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    n_cmp++; if (s_if.ready !== 1'b1) begin n_bad++; $display("FAIL ready_timeout got %0b want 1", s_if.ready); end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_ready();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (s_if.ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %0b want 0", s_if.ready); end
    n_cmp++; if (s_if.full !== 1'b1) begin n_bad++; $display("FAIL rst_full got %0b want 1", s_if.full); end
    n_cmp++; if (s_if.empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %0b want 1", s_if.empty); end
    n_cmp++; if (s_if.almost_empty !== 1'b1) begin n_bad++; $display("FAIL rst_aempty got %0b want 1", s_if.almost_empty); end
    n_cmp++; if (s_if.almost_full !== 1'b0) begin n_bad++; $display("FAIL rst_afull got %0b want 0", s_if.almost_full); end
    n_cmp++; if (s_if.count !== 5'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", s_if.count); end
    n_cmp++; if (s_if.rd_data !== 72'h0) begin n_bad++; $display("FAIL rst_rd_data got %h want 0", s_if.rd_data); end
    n_cmp++; if (s_if.rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid got %0b want 0", s_if.rd_valid); end
    // Release and keep writing: both edges before ready must drop the writes.
    rst = 1'b1;
    s_if.wr_en = 1'b1; s_if.wr_data = 72'hDEAD; f_if.wr_en = 1'b1; f_if.wr_data = 72'hBEEF;
    @(negedge clk);
    n_cmp++; if (s_if.ready !== 1'b0) begin n_bad++; $display("FAIL ready_edge1 got %0b want 0", s_if.ready); end
    @(negedge clk);
    idle_inputs();
    n_cmp++; if (s_if.ready !== 1'b1) begin n_bad++; $display("FAIL ready_edge2 got %0b want 1", s_if.ready); end
    n_cmp++; if (s_if.full !== 1'b0) begin n_bad++; $display("FAIL ready_full got %0b want 0", s_if.full); end
    n_cmp++; if (s_if.empty !== 1'b1) begin n_bad++; $display("FAIL ready_empty got %0b want 1", s_if.empty); end
    n_cmp++; if (s_if.count !== 5'd0) begin n_bad++; $display("FAIL ready_count got %0d want 0", s_if.count); end
    n_cmp++; if (s_if.overflow !== 1'b0) begin n_bad++; $display("FAIL ready_ovf got %0b want 0", s_if.overflow); end
    n_cmp++; if (f_if.count !== 5'd0) begin n_bad++; $display("FAIL ready_fwft_count got %0d want 0", f_if.count); end
  endtask

  task automatic test_std_fill_drain();
    for (int i = 0; i < 16; i++) sdat[i] = {8'(i), $urandom(), $urandom()};
    s_if.wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_if.wr_data = sdat[i];
      @(negedge clk);
      n_cmp++; if (s_if.count !== 5'(i + 1)) begin n_bad++; $display("FAIL fill_count[%0d] got %0d want %0d", i, s_if.count, i + 1); end
      n_cmp++; if (s_if.almost_empty !== (i + 1 <= 2)) begin n_bad++; $display("FAIL fill_aempty[%0d] got %0b", i, s_if.almost_empty); end
      n_cmp++; if (s_if.almost_full !== (i + 1 >= 12)) begin n_bad++; $display("FAIL fill_afull[%0d] got %0b", i, s_if.almost_full); end
      n_cmp++; if (s_if.full !== (i + 1 == 16)) begin n_bad++; $display("FAIL fill_full[%0d] got %0b", i, s_if.full); end
      n_cmp++; if (s_if.empty !== 1'b0) begin n_bad++; $display("FAIL fill_empty[%0d] got %0b want 0", i, s_if.empty); end
    end
    s_if.wr_data = 72'h0;
    @(negedge clk);
    s_if.wr_en = 1'b0;
    n_cmp++; if (s_if.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %0b want 1", s_if.overflow); end
    n_cmp++; if (s_if.count !== 5'd16) begin n_bad++; $display("FAIL ovf_count got %0d want 16", s_if.count); end
    n_cmp++; if (s_if.rd_valid !== 1'b0) begin n_bad++; $display("FAIL pre_read_valid got %0b want 0", s_if.rd_valid); end
    s_if.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_cmp++; if (s_if.rd_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d] got %0b want 1", i, s_if.rd_valid); end
      n_cmp++; if (s_if.rd_data !== sdat[i]) begin n_bad++; $display("FAIL drain_data[%0d] got %h want %h", i, s_if.rd_data, sdat[i]); end
      n_cmp++; if (s_if.count !== 5'(15 - i)) begin n_bad++; $display("FAIL drain_count[%0d] got %0d want %0d", i, s_if.count, 15 - i); end
    end
    s_if.rd_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_if.rd_valid !== 1'b0) begin n_bad++; $display("FAIL post_valid got %0b want 0", s_if.rd_valid); end
    n_cmp++; if (s_if.rd_data !== sdat[15]) begin n_bad++; $display("FAIL hold_data got %h want %h", s_if.rd_data, sdat[15]); end
    n_cmp++; if (s_if.empty !== 1'b1) begin n_bad++; $display("FAIL post_empty got %0b want 1", s_if.empty); end
    n_cmp++; if (s_if.underflow !== 1'b0) begin n_bad++; $display("FAIL pre_udf got %0b want 0", s_if.underflow); end
    s_if.rd_en = 1'b1;
    @(negedge clk);
    s_if.rd_en = 1'b0;
    n_cmp++; if (s_if.underflow !== 1'b1) begin n_bad++; $display("FAIL udf_set got %0b want 1", s_if.underflow); end
    n_cmp++; if (s_if.rd_valid !== 1'b0) begin n_bad++; $display("FAIL udf_valid got %0b want 0", s_if.rd_valid); end
  endtask

  task automatic test_fwft_latency();
    f_if.wr_en = 1'b1; f_if.wr_data = 72'h0A5;
    @(negedge clk);
    f_if.wr_en = 1'b0;
    n_cmp++; if (f_if.empty !== 1'b1) begin n_bad++; $display("FAIL fwft_edgeN_empty got %0b want 1", f_if.empty); end
    n_cmp++; if (f_if.count !== 5'd1) begin n_bad++; $display("FAIL fwft_edgeN_count got %0d want 1", f_if.count); end
    @(negedge clk);
    n_cmp++; if (f_if.empty !== 1'b0) begin n_bad++; $display("FAIL fwft_edgeN1_empty got %0b want 0", f_if.empty); end
    n_cmp++; if (f_if.rd_data !== 72'h0A5) begin n_bad++; $display("FAIL fwft_edgeN1_data got %h want 0a5", f_if.rd_data); end
    n_cmp++; if (f_if.rd_valid !== 1'b1) begin n_bad++; $display("FAIL fwft_edgeN1_valid got %0b want 1", f_if.rd_valid); end
    f_if.rd_en = 1'b1;
    @(negedge clk);
    f_if.rd_en = 1'b0;
    n_cmp++; if (f_if.empty !== 1'b1) begin n_bad++; $display("FAIL fwft_pop_empty got %0b want 1", f_if.empty); end
    n_cmp++; if (f_if.count !== 5'd0) begin n_bad++; $display("FAIL fwft_pop_count got %0d want 0", f_if.count); end
    n_cmp++; if (f_if.underflow !== 1'b0) begin n_bad++; $display("FAIL fwft_udf_pre got %0b want 0", f_if.underflow); end
    f_if.rd_en = 1'b1;
    @(negedge clk);
    f_if.rd_en = 1'b0;
    n_cmp++; if (f_if.underflow !== 1'b1) begin n_bad++; $display("FAIL fwft_udf got %0b want 1", f_if.underflow); end
  endtask

  task automatic test_fwft_stream();
    f_if.wr_en = 1'b1;
    f_if.wr_data = 72'h111; @(negedge clk);
    f_if.wr_data = 72'h222; @(negedge clk);
    f_if.wr_data = 72'h333; @(negedge clk);
    f_if.wr_en = 1'b0;
    n_cmp++; if (f_if.rd_data !== 72'h111) begin n_bad++; $display("FAIL fwft_head got %h want 111", f_if.rd_data); end
    n_cmp++; if (f_if.count !== 5'd3) begin n_bad++; $display("FAIL fwft_count3 got %0d want 3", f_if.count); end
    f_if.rd_en = 1'b1;
    @(negedge clk);
    n_cmp++; if (f_if.rd_data !== 72'h222) begin n_bad++; $display("FAIL fwft_next1 got %h want 222", f_if.rd_data); end
    @(negedge clk);
    n_cmp++; if (f_if.rd_data !== 72'h333) begin n_bad++; $display("FAIL fwft_next2 got %h want 333", f_if.rd_data); end
    n_cmp++; if (f_if.count !== 5'd1) begin n_bad++; $display("FAIL fwft_count1 got %0d want 1", f_if.count); end
    @(negedge clk);
    f_if.rd_en = 1'b0;
    n_cmp++; if (f_if.empty !== 1'b1) begin n_bad++; $display("FAIL fwft_stream_empty got %0b want 1", f_if.empty); end
  endtask

  task automatic test_simul_full();
    do_reset();
    s_if.wr_en = 1'b1;
    for (int k = 0; k < 16; k++) begin s_if.wr_data = 72'(32'h5A00 + k); @(negedge clk); end
    n_cmp++; if (s_if.full !== 1'b1) begin n_bad++; $display("FAIL sf_full got %0b want 1", s_if.full); end
    s_if.rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_if.wr_data = 72'(32'h5A00 + 16 + k);
      @(negedge clk);
      n_cmp++; if (s_if.rd_data !== 72'(32'h5A00 + k)) begin n_bad++; $display("FAIL sf_data[%0d] got %h want %h", k, s_if.rd_data, 72'(32'h5A00 + k)); end
      n_cmp++; if (s_if.count !== 5'd16) begin n_bad++; $display("FAIL sf_count[%0d] got %0d want 16", k, s_if.count); end
    end
    s_if.wr_en = 1'b0;
    n_cmp++; if (s_if.overflow !== 1'b0) begin n_bad++; $display("FAIL sf_ovf got %0b want 0", s_if.overflow); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_cmp++; if (s_if.rd_data !== 72'(32'h5A00 + 20 + k)) begin n_bad++; $display("FAIL sf_wrap[%0d] got %h want %h", k, s_if.rd_data, 72'(32'h5A00 + 20 + k)); end
    end
    s_if.rd_en = 1'b0;
    n_cmp++; if (s_if.empty !== 1'b1) begin n_bad++; $display("FAIL sf_empty got %0b want 1", s_if.empty); end
  endtask

  task automatic test_simul_empty();
    s_if.wr_en = 1'b1; s_if.rd_en = 1'b1; s_if.wr_data = 72'h123;
    @(negedge clk);
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
    n_cmp++; if (s_if.count !== 5'd1) begin n_bad++; $display("FAIL se_count got %0d want 1", s_if.count); end
    n_cmp++; if (s_if.underflow !== 1'b1) begin n_bad++; $display("FAIL se_udf got %0b want 1", s_if.underflow); end
    n_cmp++; if (s_if.rd_valid !== 1'b0) begin n_bad++; $display("FAIL se_valid got %0b want 0", s_if.rd_valid); end
    s_if.rd_en = 1'b1;
    @(negedge clk);
    s_if.rd_en = 1'b0;
    n_cmp++; if (s_if.rd_data !== 72'h123) begin n_bad++; $display("FAIL se_data got %h want 123", s_if.rd_data); end
  endtask

  task automatic test_mid_reset();
    s_if.wr_en = 1'b1;
    for (int k = 0; k < 9; k++) begin s_if.wr_data = 72'(32'h9000 + k); @(negedge clk); end
    s_if.wr_en = 1'b0;
    n_cmp++; if (s_if.count !== 5'd9) begin n_bad++; $display("FAIL mr_count9 got %0d want 9", s_if.count); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (s_if.count !== 5'd0) begin n_bad++; $display("FAIL mr_count got %0d want 0", s_if.count); end
    n_cmp++; if (s_if.full !== 1'b1) begin n_bad++; $display("FAIL mr_full got %0b want 1", s_if.full); end
    n_cmp++; if (s_if.empty !== 1'b1) begin n_bad++; $display("FAIL mr_empty got %0b want 1", s_if.empty); end
    n_cmp++; if (s_if.ready !== 1'b0) begin n_bad++; $display("FAIL mr_ready got %0b want 0", s_if.ready); end
    n_cmp++; if (s_if.underflow !== 1'b0) begin n_bad++; $display("FAIL mr_udf got %0b want 0", s_if.underflow); end
    n_cmp++; if (s_if.rd_data !== 72'h0) begin n_bad++; $display("FAIL mr_rd_data got %h want 0", s_if.rd_data); end
    n_cmp++; if (f_if.rd_data !== 72'h0) begin n_bad++; $display("FAIL mr_fwft_data got %h want 0", f_if.rd_data); end
    @(negedge clk);
    rst = 1'b1;
    wait_ready();
    s_if.wr_en = 1'b1;
    s_if.wr_data = 72'hAA; @(negedge clk);
    s_if.wr_data = 72'hBB; @(negedge clk);
    s_if.wr_en = 1'b0;
    n_cmp++; if (s_if.count !== 5'd2) begin n_bad++; $display("FAIL mr_post_count got %0d want 2", s_if.count); end
    s_if.rd_en = 1'b1;
    @(negedge clk);
    n_cmp++; if (s_if.rd_data !== 72'hAA) begin n_bad++; $display("FAIL mr_post_data0 got %h want aa", s_if.rd_data); end
    @(negedge clk);
    s_if.rd_en = 1'b0;
    n_cmp++; if (s_if.rd_data !== 72'hBB) begin n_bad++; $display("FAIL mr_post_data1 got %h want bb", s_if.rd_data); end
  endtask

  initial begin
    test_reset();
    test_std_fill_drain();
    test_fwft_latency();
    test_fwft_stream();
    test_simul_full();
    test_simul_empty();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
